// File: rtl/mdu_unit_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small operation-class helpers used by the top and the datapath.
package mdu_unit_pkg;

  typedef enum logic [2:0] {
    MDU_none  = 3'd0,
    MDU_mult  = 3'd1,
    MDU_multu = 3'd2,
    MDU_div   = 3'd3,
    MDU_divu  = 3'd4,
    MDU_mthi  = 3'd5,
    MDU_mtlo  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic isMultiCycle(input mdu_op_e op);
    return op inside {MDU_mult, MDU_multu, MDU_div, MDU_divu};
  endfunction

  function automatic logic isMultOp(input mdu_op_e op);
    return op inside {MDU_mult, MDU_multu};
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result datapath: signed/unsigned product, quotient and
// remainder, with the divide-by-zero and signed-overflow rules applied.
module mdu_calc
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_wr
);

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic signed [2*WIDTH-1:0] w_sProd;
  logic        [2*WIDTH-1:0] w_uProd;
  logic                      w_divZero;
  logic                      w_overflow;
  logic        [WIDTH-1:0]   w_sDivisor;
  logic        [WIDTH-1:0]   w_uDivisor;
  logic signed [WIDTH-1:0]   w_sQuot;
  logic signed [WIDTH-1:0]   w_sRem;
  logic        [WIDTH-1:0]   w_uQuot;
  logic        [WIDTH-1:0]   w_uRem;

  assign w_sProd = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
  assign w_uProd = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  assign w_divZero  = (i_b == '0);
  assign w_overflow = (i_a == MinNeg) && (i_b == '1);

  // Divisors are steered to 1 in the zero/overflow cases so the dividers never
  // see an undefined operation; those results are replaced or suppressed below.
  assign w_sDivisor = (w_divZero || w_overflow) ? One : i_b;
  assign w_uDivisor = w_divZero ? One : i_b;

  assign w_sQuot = $signed(i_a) / $signed(w_sDivisor);
  assign w_sRem  = $signed(i_a) % $signed(w_sDivisor);
  assign w_uQuot = i_a / w_uDivisor;
  assign w_uRem  = i_a % w_uDivisor;

  always_comb begin
    o_hi = '0;
    o_lo = '0;
    o_wr = 1'b0;
    case (i_op)
      MDU_mult: begin
        {o_hi, o_lo} = w_sProd;
        o_wr         = 1'b1;
      end
      MDU_multu: begin
        {o_hi, o_lo} = w_uProd;
        o_wr         = 1'b1;
      end
      MDU_div: begin
        o_lo = w_overflow ? MinNeg : w_sQuot;
        o_hi = w_overflow ? '0 : w_sRem;
        o_wr = !w_divZero;
      end
      MDU_divu: begin
        o_lo = w_uQuot;
        o_hi = w_uRem;
        o_wr = !w_divZero;
      end
      default: begin
        o_wr = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit: results are computed at accept, held in
// pending registers and committed to HI/LO after a fixed per-op latency.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  mdu_state_e       r_state;
  mdu_state_e       w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_pendHi;
  logic [WIDTH-1:0] r_pendLo;
  logic             r_pendWr;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  mdu_op_e          w_op;
  logic [WIDTH-1:0] w_calcHi;
  logic [WIDTH-1:0] w_calcLo;
  logic             w_calcWr;
  logic             w_accept;
  logic             w_commit;
  logic             w_mtHi;
  logic             w_mtLo;

  assign w_op = mdu_op_e'(MDUop);

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .i_op (w_op),
    .i_a  (A),
    .i_b  (B),
    .o_hi (w_calcHi),
    .o_lo (w_calcLo),
    .o_wr (w_calcWr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= MDU_IDLE;
    else        r_state <= w_nextState;
  end

  // Requests are only honoured in IDLE, so anything arriving while busy is dropped.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_mtHi      = 1'b0;
    w_mtLo      = 1'b0;
    case (r_state)
      MDU_IDLE: begin
        if (start) begin
          w_mtHi = (w_op == MDU_mthi);
          w_mtLo = (w_op == MDU_mtlo);
          if (isMultiCycle(w_op)) begin
            w_accept    = 1'b1;
            w_nextState = MDU_RUN;
          end
        end
      end
      MDU_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_nextState = MDU_IDLE;
        end
      end
      default: w_nextState = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_pendHi <= '0;
      r_pendLo <= '0;
      r_pendWr <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= isMultOp(w_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      r_pendHi <= w_calcHi;
      r_pendLo <= w_calcLo;
      r_pendWr <= w_calcWr;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // A divide by zero commits nothing, leaving the previous HI/LO in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (r_pendWr) begin
        r_hi <= r_pendHi;
        r_lo <= r_pendLo;
      end
    end else begin
      if (w_mtHi) r_hi <= A;
      if (w_mtLo) r_lo <= A;
    end
  end

  assign busy = (r_state == MDU_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit with hand-computed HI/LO values,
// busy-length checks, the busy guard, divide-by-zero, overflow and mid-run reset.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clock;
  logic        resetN;
  logic        start;
  logic [2:0]  mduOp;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checkCount = 0;
  int errorCount = 0;

  mdu_unit #(
    .WIDTH       (32),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (4)
  ) dut (
    .clk   (clock),
    .reset (resetN),
    .start (start),
    .MDUop (mduOp),
    .A     (opA),
    .B     (opB),
    .busy  (busy),
    .HI    (hi),
    .LO    (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge; holds start for exactly one cycle and returns at
  // the next falling edge, i.e. in the first cycle after the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    mduOp = op;
    opA   = a;
    opB   = b;
    @(negedge clock);
    start = 1'b0;
    mduOp = MDU_none;
  endtask

  // Counts remaining busy cycles with a hard bound, then compares the count.
  task automatic waitIdle(input string tag, input int expectedCycles);
    int n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clock);
    end
    checkOutput(tag, 32'(n), 32'(expectedCycles));
  endtask

  initial begin
    resetN = 1'b0;
    start  = 1'b0;
    mduOp  = MDU_none;
    opA    = '0;
    opB    = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_hi", hi, 32'h0);
    checkOutput("reset_lo", lo, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    resetN = 1'b1;
    @(negedge clock);

    $display("[TB] MULT -2 * 3");
    applyStimulus(MDU_mult, 32'hFFFF_FFFE, 32'h3);
    checkOutput("mult_hi_not_forwarded", hi, 32'h0);
    waitIdle("mult_busy_cycles", 5);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFFA);

    $display("[TB] MULTU max * max");
    applyStimulus(MDU_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitIdle("multu_busy_cycles", 5);
    checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", lo, 32'h0000_0001);

    $display("[TB] DIV -7 / 2");
    applyStimulus(MDU_div, 32'hFFFF_FFF9, 32'h2);
    waitIdle("div_busy_cycles", 10);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);

    $display("[TB] DIV 7 / -2");
    applyStimulus(MDU_div, 32'h7, 32'hFFFF_FFFE);
    waitIdle("div_negb_busy_cycles", 10);
    checkOutput("div_negb_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_negb_hi", hi, 32'h0000_0001);

    $display("[TB] MTHI/MTLO preload then DIVU by zero");
    applyStimulus(MDU_mthi, 32'h11, 32'h0);
    checkOutput("mthi_hi", hi, 32'h11);
    checkOutput("mthi_busy", {31'b0, busy}, 32'h0);
    applyStimulus(MDU_mtlo, 32'h22, 32'h0);
    checkOutput("mtlo_lo", lo, 32'h22);
    checkOutput("mtlo_hi_kept", hi, 32'h11);
    applyStimulus(MDU_divu, 32'h7, 32'h0);
    waitIdle("divu_zero_busy_cycles", 10);
    checkOutput("divu_zero_hi", hi, 32'h11);
    checkOutput("divu_zero_lo", lo, 32'h22);

    $display("[TB] MTHI while busy is ignored");
    applyStimulus(MDU_div, 32'd100, 32'd7);
    applyStimulus(MDU_mthi, 32'hABCD_0000, 32'h0);
    checkOutput("busy_guard_hi", hi, 32'h11);
    waitIdle("guard_div_busy_cycles", 9);
    checkOutput("guard_div_hi", hi, 32'd2);
    checkOutput("guard_div_lo", lo, 32'd14);
    applyStimulus(MDU_mthi, 32'hABCD_0000, 32'h0);
    checkOutput("late_mthi_hi", hi, 32'hABCD_0000);
    checkOutput("late_mthi_busy", {31'b0, busy}, 32'h0);

    $display("[TB] DIV signed overflow");
    applyStimulus(MDU_div, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle("ovf_busy_cycles", 10);
    checkOutput("ovf_lo", lo, 32'h8000_0000);
    checkOutput("ovf_hi", hi, 32'h0);

    $display("[TB] start with MDU_none");
    applyStimulus(MDU_none, 32'h1234_5678, 32'h9);
    checkOutput("none_busy", {31'b0, busy}, 32'h0);
    checkOutput("none_lo", lo, 32'h8000_0000);
    checkOutput("none_hi", hi, 32'h0);

    $display("[TB] reset during DIV");
    applyStimulus(MDU_div, 32'd9, 32'd2);
    repeat (3) @(negedge clock);
    checkOutput("pre_reset_busy", {31'b0, busy}, 32'h1);
    resetN = 1'b0;
    #1;
    checkOutput("midrun_reset_hi", hi, 32'h0);
    checkOutput("midrun_reset_lo", lo, 32'h0);
    checkOutput("midrun_reset_busy", {31'b0, busy}, 32'h0);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    applyStimulus(MDU_mult, 32'd2, 32'd3);
    waitIdle("post_reset_mult_busy_cycles", 5);
    checkOutput("post_reset_mult_lo", lo, 32'd6);
    checkOutput("post_reset_mult_hi", hi, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the combinational ALU.
- Accepts one operation per start pulse, holds busy for a fixed per-op latency, then commits to HI/LO.
- Stall logic in the hazard unit uses start|busy to freeze the pipeline on any MDU-dependent instruction.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).
- CNT_W, 4, countdown counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  operation request, valid for one cycle.
- MDUop  input  3  operation code: MDU_none, MDU_mult, MDU_multu, MDU_div, MDU_divu, MDU_mthi, MDU_mtlo.
- A  input  WIDTH  rs operand.
- B  input  WIDTH  rt operand.
- busy  output  1  registered; high while an operation is in flight.
- HI  output  WIDTH  architectural HI, registered.
- LO  output  WIDTH  architectural LO, registered.

Behaviour:
- Reset (reset==0, async): HI=0, LO=0, busy=0, counter=0, pending regs=0, state=IDLE.
- States:
  - IDLE -> RUN on start with a mult/div op and busy==0.
  - RUN -> IDLE when counter reaches 1, at the committing edge.
- Accept: at the edge ending cycle t with start=1, busy=0, and op in {mult, multu, div, divu}:
  - Latch result into pend_hi/pend_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from cycle t+1.
- Countdown: counter decrements every cycle in RUN. At the edge where counter==1:
  - HI<=pend_hi, LO<=pend_lo.
  - busy<=0.
  - New values are visible and busy low in cycle t+N+1, where N is the op latency.
- Results:
  - MULT: {HI,LO} = signed A*B, 2*WIDTH bits.
  - MULTU: {HI,LO} = unsigned A*B.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of A.
  - DIVU: unsigned LO = A/B, HI = A%B.
- MTHI/MTLO:
  - With start=1 and busy=0, write A to HI/LO at the next edge.
  - Single cycle; busy stays 0.
- Divide by zero (B==0, DIV or DIVU): busy sequence runs normally, but HI/LO retain their old values at commit.
- Signed overflow (DIV, A=min negative, B=all ones): LO=min negative (0x80000000 at WIDTH=32), HI=0.
- start while busy=1: ignored entirely (any op, including mthi/mtlo); no state change. The hazard unit guarantees this does not occur, and the bench checks the guard.
- start with MDU_none: no effect.
- HI/LO outputs always reflect committed state; pending values are never forwarded.
- Reset asserted mid-RUN: operation discarded, all registers return to reset values immediately.
- Counter never wraps: it only loads on accept and decrements while nonzero.

Decomposition:
- Shared macro file gets:
  - MDUop encodings (MDU_none=0, MDU_mult=1, MDU_multu=2, MDU_div=3, MDU_divu=4, MDU_mthi=5, MDU_mtlo=6).
  - State encodings MDU_IDLE=0, MDU_RUN=1.
- The result datapath (signed/unsigned product, quotient, remainder, zero/overflow rules) is one combinational sub-module, mdu_calc.
- The mdu_unit top holds the FSM, counter, pending and HI/LO registers.

Test Plan:
- MULT, A=0xFFFFFFFE (-2), B=3, defaults -> busy high cycles t+1..t+5; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, A=7, B=0, with HI=0x11 and LO=0x22 preloaded via MTHI/MTLO -> busy 10 cycles, then HI=0x11, LO=0x22 unchanged.
- MTHI A=0xABCD0000 while busy=1 from a prior DIV -> ignored; HI after commit equals the DIV remainder; MTHI issued after busy falls -> HI=0xABCD0000 next cycle, busy stays 0.
- Start DIV, drop reset low at busy cycle 4 -> HI=LO=0 and busy=0 immediately; after release a new MULT 2*3 gives LO=6, HI=0 with 5-cycle busy.
